// File: rtl/mult_secuenciador_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// Holds the 3-bit binary state encoding and the product-register width
// expression. The Datapath and the future mult_top import the same package,
// so they agree on both.
package mult_secuenciador_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    TEST_Q0 = 3'd2,
    ADD     = 3'd3,
    SHIFT   = 3'd4,
    TEST_Z  = 3'd5,
    CAPTURE = 3'd6,
    DONE    = 3'd7
  } state_e;

  // Width of the Datapath product register: carry bit plus 2*ANCHO bits.
  function automatic int prod_w(input int ancho);
    return 2 * ancho + 1;
  endfunction

endpackage

// File: rtl/mult_secuenciador.sv
// Control unit for a shift-add multiplier Datapath.
// Latches two operands on a start request, sequences the Datapath with
// Load/Add/Shift/Decrement commands based on its Q0 and counter-zero flags,
// then captures the product and reports completion with a one-cycle Done
// pulse. An iteration watchdog catches a Datapath counter that never
// reaches zero, and a leftover carry bit also flags Error.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   Start               request, sampled only in IDLE
//   A_in, B_in          operands for the request
//   Q_Cero, Zero        Datapath flags (Q0 bit, counter zero)
//   Producto            Datapath product register, carry in the top bit
//   Multiplicando/Multiplicador  latched operands, held through the operation
//   Load_regs, Shift_regs, Add_regs, Decr_P   Datapath commands (Moore)
//   Busy, Done          status (Moore); Done is a one-cycle pulse
//   Resultado           captured low 2*ANCHO product bits
//   Error               status of the last operation, valid with Done
module mult_secuenciador
  import mult_secuenciador_pkg::*;
#(
  parameter int ANCHO = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Start,
  input  logic [ANCHO-1:0]           A_in,
  input  logic [ANCHO-1:0]           B_in,
  input  logic                       Q_Cero,
  input  logic                       Zero,
  input  logic [prod_w(ANCHO)-1:0]   Producto,
  output logic [ANCHO-1:0]           Multiplicando,
  output logic [ANCHO-1:0]           Multiplicador,
  output logic                       Load_regs,
  output logic                       Shift_regs,
  output logic                       Add_regs,
  output logic                       Decr_P,
  output logic                       Busy,
  output logic                       Done,
  output logic [2*ANCHO-1:0]         Resultado,
  output logic                       Error
);

  // Wide enough to hold ANCHO itself so the watchdog compare never sees a wrap.
  localparam int CW = $clog2(ANCHO + 1);

  state_e             state_q, state_d;
  logic [ANCHO-1:0]   mcand_q, mcand_d;
  logic [ANCHO-1:0]   mplier_q, mplier_d;
  logic [2*ANCHO-1:0] res_q, res_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          mcand_d  = A_in;
          mplier_d = B_in;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD:    state_d = TEST_Q0;
      TEST_Q0: state_d = Q_Cero ? ADD : SHIFT;
      ADD:     state_d = SHIFT;
      SHIFT: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = TEST_Z;
      end
      TEST_Z: begin
        if (Zero) begin
          state_d = CAPTURE;
        end else if (cnt_q == CW'(ANCHO)) begin
          // Datapath counter never reached zero: stop anyway and flag it.
          err_d   = 1'b1;
          state_d = CAPTURE;
        end else begin
          state_d = TEST_Q0;
        end
      end
      CAPTURE: begin
        res_d = Producto[2*ANCHO-1:0];
        if (Producto[2*ANCHO]) err_d = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs, decoded from the state register only.
  always_comb begin
    Load_regs  = 1'b0;
    Shift_regs = 1'b0;
    Add_regs   = 1'b0;
    Decr_P     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      IDLE:    ;
      LOAD:    begin Load_regs = 1'b1; Busy = 1'b1; end
      TEST_Q0: Busy = 1'b1;
      ADD:     begin Add_regs = 1'b1; Busy = 1'b1; end
      SHIFT:   begin Shift_regs = 1'b1; Decr_P = 1'b1; Busy = 1'b1; end
      TEST_Z:  Busy = 1'b1;
      CAPTURE: Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign Multiplicando = mcand_q;
  assign Multiplicador = mplier_q;
  assign Resultado     = res_q;
  assign Error         = err_q;

endmodule

// File: tb/tb_mult_secuenciador.sv
module tb_mult_secuenciador;

  localparam int ANCHO = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               Start = 1'b0;
  logic [ANCHO-1:0]   A_in = '0;
  logic [ANCHO-1:0]   B_in = '0;
  logic               Q_Cero;
  logic               Zero;
  logic [2*ANCHO:0]   Producto;
  logic [ANCHO-1:0]   Multiplicando, Multiplicador;
  logic               Load_regs, Shift_regs, Add_regs, Decr_P, Busy, Done, Error;
  logic [2*ANCHO-1:0] Resultado;

  mult_secuenciador #(.ANCHO(ANCHO)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A_in(A_in), .B_in(B_in),
    .Q_Cero(Q_Cero), .Zero(Zero), .Producto(Producto),
    .Multiplicando(Multiplicando), .Multiplicador(Multiplicador),
    .Load_regs(Load_regs), .Shift_regs(Shift_regs), .Add_regs(Add_regs),
    .Decr_P(Decr_P), .Busy(Busy), .Done(Done), .Resultado(Resultado),
    .Error(Error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shift-add Datapath, with stub controls for fault injection.
  logic [ANCHO-1:0] dp_m = '0, dp_q = '0, dp_acc = '0;
  logic             dp_c = 1'b0;
  logic [3:0]       dp_p = '0;
  logic             stub_z = 1'b0, stub_c = 1'b0;

  always @(posedge clk) begin
    if (Load_regs) begin
      dp_m   <= Multiplicando;
      dp_q   <= Multiplicador;
      dp_acc <= '0;
      dp_c   <= 1'b0;
    end else if (Add_regs) begin
      {dp_c, dp_acc} <= {1'b0, dp_acc} + {1'b0, dp_m};
    end else if (Shift_regs) begin
      {dp_c, dp_acc, dp_q} <= {1'b0, dp_c, dp_acc, dp_q[ANCHO-1:1]};
    end
    if (Load_regs)   dp_p <= 4'(ANCHO);
    else if (Decr_P) dp_p <= dp_p - 4'd1;
  end

  assign Q_Cero   = dp_q[0];
  assign Zero     = stub_z ? 1'b0 : (dp_p == 4'd0);
  assign Producto = {dp_c | stub_c, dp_acc, dp_q};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [ANCHO-1:0]   a;
    logic [ANCHO-1:0]   b;
    logic [2*ANCHO-1:0] res;
    logic               err;
    int                 done_cyc;
    int                 adds;
  } exp_t;

  exp_t sb[$];

  int   add_cnt = 0;
  int   sh_cnt  = 0;
  logic prev_done = 1'b0;

  // Monitor: pops the scoreboard on every Done pulse.
  always @(negedge clk) begin
    if (Load_regs) begin
      add_cnt <= 0;
      sh_cnt  <= 0;
    end else begin
      if (Add_regs)   add_cnt <= add_cnt + 1;
      if (Shift_regs) sh_cnt  <= sh_cnt + 1;
    end
    if (prev_done) chk("done_width", 32'(Done), 32'd0);
    if (Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("resultado", 32'(Resultado), 32'(sb[0].res));
        chk("error",     32'(Error),     32'(sb[0].err));
        chk("latency",   cyc,            sb[0].done_cyc);
        chk("adds",      add_cnt,        sb[0].adds);
        chk("shifts",    sh_cnt,         ANCHO);
        chk("mcand",     32'(Multiplicando), 32'(sb[0].a));
        chk("mplier",    32'(Multiplicador), 32'(sb[0].b));
        chk("busy_in_done", 32'(Busy), 32'd0);
        sb.pop_front();
      end
    end
    prev_done <= Done;
  end

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (Done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  // One operation. intr: cycle of an ignored second Start (0 = none).
  // rstc: cycle of a mid-operation reset (0 = none).
  task automatic run_op(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                        input logic z, input logic c, input int intr, input int rstc);
    exp_t e;
    int   s;
    @(negedge clk);
    stub_z = z;
    stub_c = c;
    A_in   = a;
    B_in   = b;
    Start  = 1'b1;
    s      = cyc + 1;
    e.a = a; e.b = b;
    e.res = 16'(a * b);
    e.err = z | c;
    e.adds = $countones(b);
    e.done_cyc = s + 2 + 3 * ANCHO + $countones(b);
    sb.push_back(e);
    @(negedge clk);
    Start = 1'b0;
    A_in  = 8'($urandom);
    B_in  = 8'($urandom);
    if (intr > 0) begin
      while (cyc < s + intr - 1) @(negedge clk);
      A_in = 8'h01; B_in = 8'h01; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
    end
    if (rstc > 0) begin
      while (cyc < s + rstc - 1) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy",  32'(Busy),       32'd0);
      chk("rst_cmds",  32'({Load_regs, Shift_regs, Add_regs, Decr_P}), 32'd0);
      chk("rst_done",  32'(Done),       32'd0);
      chk("rst_mcand", 32'(Multiplicando), 32'd0);
      chk("rst_res",   32'(Resultado),  32'd0);
      repeat (40) @(negedge clk);
    end else begin
      wait_done();
    end
    stub_z = 1'b0;
    stub_c = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({Load_regs, Shift_regs, Add_regs, Decr_P, Busy, Done, Error}), 32'd0);
    chk("reset_res",     32'(Resultado), 32'd0);
    chk("reset_ops",     32'({Multiplicando, Multiplicador}), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(Busy), 32'd0);

    run_op(8'hD7, 8'h17, 1'b0, 1'b0, 0, 0);
    run_op(8'h5A, 8'h00, 1'b0, 1'b0, 0, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 0, 0);
    run_op(8'hD7, 8'h17, 1'b0, 1'b0, 10, 0);
    run_op(8'h3C, 8'hA5, 1'b1, 1'b0, 0, 0);
    run_op(8'h81, 8'h42, 1'b0, 1'b1, 0, 0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 0);
    run_op(8'h77, 8'h99, 1'b0, 1'b0, 0, 12);
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++)
      run_op(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 0);

    // Start held high: two back-to-back operations, one IDLE cycle between.
    begin
      exp_t e1, e2;
      int   s;
      @(negedge clk);
      A_in = 8'h0B; B_in = 8'h0D; Start = 1'b1;
      s = cyc + 1;
      e1.a = 8'h0B; e1.b = 8'h0D; e1.res = 16'd143; e1.err = 1'b0; e1.adds = 3;
      e1.done_cyc = s + 2 + 3 * ANCHO + 3;
      e2 = e1;
      e2.done_cyc = e1.done_cyc + 2 + 2 + 3 * ANCHO + 3;
      sb.push_back(e1);
      sb.push_back(e2);
      wait_done();
      @(negedge clk);
      chk("b2b_idle", 32'({Busy, Load_regs}), 32'd0);
      @(negedge clk);
      chk("b2b_load", 32'(Load_regs), 32'd1);
      Start = 1'b0;
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
